// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath
// (PC, instruction register, register file, memory port), plus the ALU-control
// decoder.
//
// Build option:
//   MC_CTRL_ADDI_EN - when defined, adds the ADDIEXEC/ADDIWB states so that
//                     op=001000 executes as addi; otherwise addi is illegal.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, forces FETCH
//   op[5:0]    in   opcode field from the instruction register
//   funct[5:0] in   R-type function field
//   zero       in   ALU zero flag (used only in BRANCH)
//   pcen       out  PC load enable = pcwrite | (branch & zero)
//   pcwrite    out  unconditional PC write
//   branch     out  conditional PC write
//   irwrite    out  instruction register load
//   regwrite   out  register file write
//   memwrite   out  data memory write
//   iord       out  memory address select (0 PC, 1 ALU result reg)
//   memtoreg   out  write-back select (1 memory data, 0 ALU result)
//   regdst     out  destination select (1 rd, 0 rt)
//   alusrca    out  ALU A select (0 PC, 1 reg A)
//   alusrcb    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsrc      out  next-PC select (00 ALU, 01 ALU result reg, 10 jump)
//   alucontrol out  ALU operation code
//   illegal    out  unsupported opcode seen in DECODE
//   state      out  current state code (debug)
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       pcwrite,
  output logic       branch,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_illegal;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next     = S_FETCH;
    w_aluop    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_illegal  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEXEC;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // op is held stable from DECODE; anything else here just retires.
        if (op == OP_LW) begin
          w_next = S_MEMRD;
        end else if (op == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
`endif
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        // Unused codes (and 9/10 without addi support) fall back to FETCH.
        w_next = S_FETCH;
      end
    endcase
  end

  // ALU control decoder.
  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write enables are suppressed for as long as reset is held, so the
  // FETCH writes only start once reset is released.
  assign pcwrite  = w_pcwrite  & ~reset;
  assign branch   = w_branch   & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign illegal  = w_illegal  & ~reset;
  assign pcen     = pcwrite | (branch & zero);
  assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, pcwrite, branch, irwrite, regwrite, memwrite;
  logic       iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite),
    .regwrite(regwrite), .memwrite(memwrite), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample mid-cycle.
  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    step(); step();

    // Reset state: FETCH, enables gated off, selects at FETCH values
    chk("rst_state",   {4'd0, state},    8'd0);
    chk("rst_pcwrite", {7'd0, pcwrite},  8'd0);
    chk("rst_irwrite", {7'd0, irwrite},  8'd0);
    chk("rst_pcen",    {7'd0, pcen},     8'd0);
    chk("rst_alusrcb", {6'd0, alusrcb},  8'd1);
    chk("rst_aluctl",  {5'd0, alucontrol}, 8'd2);

    // Release: first FETCH writes
    reset = 1'b0;
    op    = 6'b100011; // lw
    #1;
    chk("fetch_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    chk("fetch_pcen",    {7'd0, pcen},    8'd1);

    // lw: 0,1,2,3,4,0
    step();
    chk("lw_s1",       {4'd0, state},   8'd1);
    chk("lw_dec_srcb", {6'd0, alusrcb}, 8'd3);
    chk("lw_dec_ill",  {7'd0, illegal}, 8'd0);
    chk("lw_dec_pcen", {7'd0, pcen},    8'd0);
    step();
    chk("lw_s2",       {4'd0, state},   8'd2);
    chk("lw_adr_srca", {7'd0, alusrca}, 8'd1);
    chk("lw_adr_srcb", {6'd0, alusrcb}, 8'd2);
    step();
    chk("lw_s3",       {4'd0, state},    8'd3);
    chk("lw_rd_iord",  {7'd0, iord},     8'd1);
    chk("lw_rd_rw",    {7'd0, regwrite}, 8'd0);
    step();
    chk("lw_s4",       {4'd0, state},    8'd4);
    chk("lw_wb_rw",    {7'd0, regwrite}, 8'd1);
    chk("lw_wb_m2r",   {7'd0, memtoreg}, 8'd1);
    chk("lw_wb_iord",  {7'd0, iord},     8'd0);
    step();
    chk("lw_s0",       {4'd0, state},    8'd0);
    chk("lw_end_rw",   {7'd0, regwrite}, 8'd0);

    // Second lw, interrupted by reset in MEMRD
    step(); step(); step();
    chk("rmid_s3", {4'd0, state}, 8'd3);
    reset = 1'b1;
    #1;
    chk("rmid_state",   {4'd0, state},    8'd0);
    chk("rmid_pcwrite", {7'd0, pcwrite},  8'd0);
    chk("rmid_irwrite", {7'd0, irwrite},  8'd0);
    chk("rmid_rw",      {7'd0, regwrite}, 8'd0);
    chk("rmid_mw",      {7'd0, memwrite}, 8'd0);
    chk("rmid_iord",    {7'd0, iord},     8'd0);
    step();
    chk("rmid_hold",    {4'd0, state},    8'd0);
    chk("rmid_hold_pc", {7'd0, pcen},     8'd0);
    reset = 1'b0;
    op    = 6'b101011; // sw
    #1;
    chk("rrel_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("rrel_irwrite", {7'd0, irwrite}, 8'd1);

    // sw: 0,1,2,5,0
    step();
    chk("sw_s1", {4'd0, state}, 8'd1);
    step();
    chk("sw_s2", {4'd0, state}, 8'd2);
    step();
    chk("sw_s5",   {4'd0, state},    8'd5);
    chk("sw_mw",   {7'd0, memwrite}, 8'd1);
    chk("sw_iord", {7'd0, iord},     8'd1);
    step();
    chk("sw_s0",   {4'd0, state},    8'd0);
    chk("sw_mw0",  {7'd0, memwrite}, 8'd0);

    // R-type slt: 0,1,6,7,0
    op    = 6'b000000;
    funct = 6'b101010;
    step();
    chk("rt_s1", {4'd0, state}, 8'd1);
    step();
    chk("rt_s6",     {4'd0, state},      8'd6);
    chk("rt_slt",    {5'd0, alucontrol}, 8'd7);
    chk("rt_srca",   {7'd0, alusrca},    8'd1);
    chk("rt_srcb",   {6'd0, alusrcb},    8'd0);
    funct = 6'b100101;
    #1;
    chk("rt_or",     {5'd0, alucontrol}, 8'd1);
    funct = 6'b100010;
    #1;
    chk("rt_sub",    {5'd0, alucontrol}, 8'd6);
    funct = 6'b111111;
    #1;
    chk("rt_other",  {5'd0, alucontrol}, 8'd0);
    funct = 6'b101010;
    step();
    chk("rt_s7",     {4'd0, state},    8'd7);
    chk("rt_regdst", {7'd0, regdst},   8'd1);
    chk("rt_rw",     {7'd0, regwrite}, 8'd1);
    step();
    chk("rt_s0", {4'd0, state}, 8'd0);

    // beq with zero=1 then zero=0: 0,1,8,0
    op   = 6'b000100;
    zero = 1'b1;
    step();
    chk("beq_s1", {4'd0, state}, 8'd1);
    chk("beq_dec_pcen", {7'd0, pcen}, 8'd0);
    step();
    chk("beq_s8",     {4'd0, state},      8'd8);
    chk("beq_z1_pcen", {7'd0, pcen},      8'd1);
    chk("beq_pcsrc",  {6'd0, pcsrc},      8'd1);
    chk("beq_alu",    {5'd0, alucontrol}, 8'd6);
    chk("beq_pcw",    {7'd0, pcwrite},    8'd0);
    zero = 1'b0;
    #1;
    chk("beq_z0_pcen", {7'd0, pcen},   8'd0);
    chk("beq_branch",  {7'd0, branch}, 8'd1);
    step();
    chk("beq_s0", {4'd0, state}, 8'd0);
    step();
    step();
    chk("beq2_s8",     {4'd0, state},      8'd8);
    chk("beq2_pcen",   {7'd0, pcen},       8'd0);
    chk("beq2_pcsrc",  {6'd0, pcsrc},      8'd1);
    chk("beq2_alu",    {5'd0, alucontrol}, 8'd6);
    step();

    // j: 0,1,11,0
    op = 6'b000010;
    step();
    chk("j_s1", {4'd0, state}, 8'd1);
    step();
    chk("j_s11",   {4'd0, state}, 8'd11);
    chk("j_pcsrc", {6'd0, pcsrc}, 8'd2);
    chk("j_pcen",  {7'd0, pcen},  8'd1);
    step();
    chk("j_s0", {4'd0, state}, 8'd0);

    // addi
    op = 6'b001000;
    step();
    chk("addi_s1", {4'd0, state}, 8'd1);
`ifdef MC_CTRL_ADDI_EN
    chk("addi_ill", {7'd0, illegal}, 8'd0);
    step();
    chk("addi_s9",   {4'd0, state},   8'd9);
    chk("addi_srca", {7'd0, alusrca}, 8'd1);
    chk("addi_srcb", {6'd0, alusrcb}, 8'd2);
    step();
    chk("addi_s10", {4'd0, state},    8'd10);
    chk("addi_rw",  {7'd0, regwrite}, 8'd1);
    chk("addi_rd",  {7'd0, regdst},   8'd0);
    step();
    chk("addi_s0", {4'd0, state}, 8'd0);
`else
    chk("addi_ill", {7'd0, illegal}, 8'd1);
    step();
    chk("addi_s0",   {4'd0, state},   8'd0);
    chk("addi_ill0", {7'd0, illegal}, 8'd0);
`endif

    // Unsupported opcode: 0,1,0 with one-cycle illegal
    op = 6'b111111;
    step();
    chk("ill_s1", {4'd0, state},   8'd1);
    chk("ill_fl", {7'd0, illegal}, 8'd1);
    chk("ill_rw", {7'd0, regwrite}, 8'd0);
    step();
    chk("ill_s0",  {4'd0, state},   8'd0);
    chk("ill_fl0", {7'd0, illegal}, 8'd0);
    chk("ill_pcw", {7'd0, pcwrite}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that sequences the shared datapath registers (PC, instruction register, register file, memory port) for the MIPS core, one instruction at a time. It is a Moore FSM with an ALU-control decoder. It drives the enables for the PC register, instruction register, register file and memory, plus the datapath multiplexer selects. The PC register itself stays a plain register; this block decides when it loads and from which source.

## Interface
Parameters:
- none; all widths are fixed by the MIPS ISA.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
- op  input  6  instruction opcode field, from the instruction register.
- funct  input  6  R-type function field, from the instruction register.
- zero  input  1  ALU zero flag.
- pcen  output  1  PC load enable, equal to pcwrite | (branch & zero).
- pcwrite  output  1  unconditional PC write.
- branch  output  1  conditional PC write, qualified by zero.
- irwrite  output  1  instruction register load.
- regwrite  output  1  register file write.
- memwrite  output  1  data memory write.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
- memtoreg  output  1  write-back select: 1 = memory data, 0 = ALU result.
- regdst  output  1  destination register select: 1 = rd, 0 = rt.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- pcsrc  output  2  next-PC select: 00 = ALU output, 01 = ALU result register, 10 = jump target.
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  output  1  one-cycle flag, high in DECODE when the opcode is unsupported.
- state  output  4  current state code, for debug.

## Operation
- State codes: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECUTE, 7 ALUWB, 8 BRANCH, 9 ADDIEXEC, 10 ADDIWB, 11 JUMP. Codes 12–15 go to FETCH on the next edge.
- Any output not listed for a state is 0. The aluop field (00 add, 01 sub, 10 funct) is internal only.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next state: DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEXEC, only when the feature macro is defined.
  - anything else → FETCH, with illegal=1.
- MEMADR: alusrca=1, alusrcb=10. Next state: MEMRD if op=lw, MEMWR if op=sw.
- MEMRD: iord=1. Next state: MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next state: FETCH.
- MEMWR: iord=1, memwrite=1. Next state: FETCH.
- EXECUTE: alusrca=1, aluop=10. Next state: ALUWB.
- ALUWB: regwrite=1, regdst=1. Next state: FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. Next state: FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10. Next state: ADDIWB.
- ADDIWB: regwrite=1. Next state: FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state: FETCH.
- ALU decoder:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10, by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→000.
- All outputs except pcen are pure functions of state and op/funct. pcen also depends combinationally on zero.

## Timing
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset assertion:
  - state becomes FETCH (state=0) asynchronously.
  - While reset=1, pcen, pcwrite, branch, irwrite, regwrite, memwrite and illegal are forced to 0; the select outputs show their FETCH values.
  - The first FETCH writes occur in the first cycle after reset deasserts.
- Reset mid-instruction: the instruction is abandoned with no further writes, and execution resumes at FETCH.
- op and funct must stay stable from DECODE to instruction end; the instruction register loads only in FETCH.
- zero is sampled combinationally in BRANCH only; pcen=1 in BRANCH if and only if zero=1.

## Configuration
- MC_CTRL_ADDI_EN defined: states 9 and 10 are compiled in, and op=001000 executes as addi.
- MC_CTRL_ADDI_EN undefined: states 9 and 10 do not exist, op=001000 raises illegal in DECODE, and codes 9–10 go to FETCH like any unused code.

## Test plan
- Reset pulse mid-MEMRD → state=0 immediately, all write enables 0 while reset is high; after release, FETCH with pcwrite=1 and irwrite=1.
- lw (op=100011) → states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; iord=1 in state 3.
- R-type, funct=101010 → states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
- beq with zero=1, then with zero=0 → state 8 gives pcen=1, then pcen=0; pcsrc=01 and alucontrol=110 in both cases.
- j (op=000010) → states 0,1,11,0; pcsrc=10 and pcen=1 in state 11.
- op=001000 → with MC_CTRL_ADDI_EN: states 0,1,9,10,0 and regwrite=1 in state 10. Without it: states 0,1,0 and illegal=1 for one cycle in DECODE.
